updown_counter_7seg: RTL and testbench

Parametrised up/down modulo counter with an integrated tick prescaler and a multi-digit hex 7-segment display driver. The counter advances once per prescaled tick, in clk's domain; no derived clocks are used. It provides direction control, pause, synchronous load and a wrap pulse. It drives the board's common-anode 7-segment displays directly and serves as the general timing/counting display block for lab designs.

---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_hex_decoder.sv | 15 +
 rtl/updown_counter_7seg.sv | 115 +++++++++++
 tb/tb_updown_counter_7seg.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment vector type and active-low hex glyphs.
// Bit order within seg_t is {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to 7-segment decoder with selectable output polarity.
module seg7_hex_decoder
  import seg7_pkg::*;
#(
  parameter bit active_low = 1'b1
) (
  input  logic [3:0] hex,
  output seg_t       seg
);

  always_comb begin
    seg = active_low ? SEG_HEX[hex] : ~SEG_HEX[hex];
  end

endmodule

// File: rtl/updown_counter_7seg.sv
// Prescaled up/down modulo counter with clamped synchronous load, wrap pulse and
// registered multi-digit hex 7-segment outputs. Reset is synchronous, active-low.
module updown_counter_7seg
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned TICK_HZ        = 1,
  parameter int unsigned DIGITS         = 2,
  parameter int unsigned MODULO         = 16 ** DIGITS,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  wrap,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int unsigned CW  = 4 * DIGITS;
  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(MODULO - 1);

  localparam seg_t                SEG_ZERO  = SEG_ACTIVE_LOW ? SEG_HEX[0] : ~SEG_HEX[0];
  localparam logic [7*DIGITS-1:0] SEG_RESET = {DIGITS{SEG_ZERO}};

  if (DIV < 2) begin : g_div_err
    $error("updown_counter_7seg: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (CLK_HZ % TICK_HZ != 0) begin : g_int_err
    $error("updown_counter_7seg: CLK_HZ must be an integer multiple of TICK_HZ");
  end
  if (MODULO < 2 || MODULO > 16 ** DIGITS) begin : g_mod_err
    $error("updown_counter_7seg: MODULO must lie in 2..16**DIGITS");
  end

  logic [PW-1:0]       presc_q, presc_d;
  logic [CW-1:0]       count_q, count_d;
  logic                tick_q, tick_d;
  logic                wrap_q, wrap_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic                step;

  assign step = en && (presc_q == PRESC_MAX);

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    // Load overrides a coincident step, suppressing both tick and wrap.
    if (load) begin
      presc_d = '0;
      count_d = (load_val > COUNT_MAX) ? COUNT_MAX : load_val;
    end else if (step) begin
      presc_d = '0;
      tick_d  = 1'b1;
      if (up) begin
        if (count_q == COUNT_MAX) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = COUNT_MAX;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end else if (en) begin
      presc_d = presc_q + 1'b1;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    seg7_hex_decoder #(
      .active_low (SEG_ACTIVE_LOW)
    ) u_dec (
      .hex (count_q[4*i +: 4]),
      .seg (seg_d[7*i +: 7])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      seg_q   <= SEG_RESET;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      seg_q   <= seg_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;
  assign seg   = seg_q;

endmodule

// File: tb/tb_updown_counter_7seg.sv
// Bench for updown_counter_7seg: three instances (MODULO 12 active-low, 256 active-low,
// 12 inverted polarity) driven in lockstep and compared against an arithmetic model.
module tb_updown_counter_7seg;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       reset, en, up, load;
  logic [7:0] load_val;

  logic [7:0]  cnt_w  [3];
  logic        tick_w [3];
  logic        wrap_w [3];
  logic [13:0] seg_w  [3];

  int n_pass  = 0;
  int n_total = 0;

  int          m_presc [3];
  int          m_cnt   [3];
  bit          m_tick  [3];
  bit          m_wrap  [3];
  logic [13:0] m_seg   [3];
  int          mod_tab [3] = '{12, 256, 12};
  bit          pol_low [3] = '{1'b1, 1'b1, 1'b0};

  logic [6:0] hex_pat [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always #5 clk = ~clk;

  updown_counter_7seg #(
    .CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .MODULO(12), .SEG_ACTIVE_LOW(1'b1)
  ) u_dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt_w[0]), .tick(tick_w[0]), .wrap(wrap_w[0]), .seg(seg_w[0])
  );

  updown_counter_7seg #(
    .CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .MODULO(256), .SEG_ACTIVE_LOW(1'b1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt_w[1]), .tick(tick_w[1]), .wrap(wrap_w[1]), .seg(seg_w[1])
  );

  updown_counter_7seg #(
    .CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .MODULO(12), .SEG_ACTIVE_LOW(1'b0)
  ) u_dut_c (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt_w[2]), .tick(tick_w[2]), .wrap(wrap_w[2]), .seg(seg_w[2])
  );

  function automatic logic [13:0] enc(int v, bit low);
    logic [6:0] d0, d1;
    d0 = hex_pat[v % 16];
    d1 = hex_pat[(v / 16) % 16];
    if (!low) begin
      d0 = ~d0;
      d1 = ~d1;
    end
    return {d1, d0};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance the reference by one clock edge using the inputs currently applied.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (!reset) begin
        m_presc[k] = 0;
        m_cnt[k]   = 0;
        m_tick[k]  = 1'b0;
        m_wrap[k]  = 1'b0;
        m_seg[k]   = enc(0, pol_low[k]);
      end else begin
        m_seg[k]  = enc(m_cnt[k], pol_low[k]);
        m_tick[k] = 1'b0;
        m_wrap[k] = 1'b0;
        if (load) begin
          m_cnt[k]   = (int'(load_val) >= mod_tab[k]) ? mod_tab[k] - 1 : int'(load_val);
          m_presc[k] = 0;
        end else if (en) begin
          if (m_presc[k] == DIV - 1) begin
            m_presc[k] = 0;
            m_tick[k]  = 1'b1;
            if (up) begin
              m_wrap[k] = (m_cnt[k] == mod_tab[k] - 1);
              m_cnt[k]  = (m_cnt[k] + 1) % mod_tab[k];
            end else begin
              m_wrap[k] = (m_cnt[k] == 0);
              m_cnt[k]  = (m_cnt[k] + mod_tab[k] - 1) % mod_tab[k];
            end
          end else begin
            m_presc[k]++;
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("count%0d", k), cnt_w[k], m_cnt[k]);
      check($sformatf("tick%0d", k), tick_w[k], m_tick[k]);
      check($sformatf("wrap%0d", k), wrap_w[k], m_wrap[k]);
      check($sformatf("seg%0d", k), seg_w[k], m_seg[k]);
    end
  endtask

  task automatic wait_tick(int k, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!tick_w[k] && n < 100);
    if (!tick_w[k]) check("tick_timeout", tick_w[k], 1);
  endtask

  task automatic wait_presc(int k, int val);
    for (int i = 0; i < 50; i++) begin
      if (m_presc[k] == val) break;
      cycle();
    end
    if (m_presc[k] != val) check("presc_timeout", m_presc[k], val);
  endtask

  initial begin
    int n;
    int frozen;

    reset    = 1'b0;
    en       = 1'b1;
    up       = 1'b1;
    load     = 1'b0;
    load_val = 8'd0;

    // Reset then first step DIV cycles after release
    repeat (3) cycle();
    check("rst_count", cnt_w[0], 0);
    check("rst_seg", seg_w[0], 14'b1000000_1000000);
    check("rst_seg_inv", seg_w[2], 14'b0111111_0111111);
    reset = 1'b1;
    wait_tick(0, n);
    check("first_tick_lat", n, DIV);
    check("first_count", cnt_w[0], 1);
    cycle();
    check("first_seg_d0", seg_w[0][6:0], 7'b1111001);
    check("first_seg_d0_inv", seg_w[2][6:0], 7'b0000110);

    // Up-count wrap at MODULO-1
    for (int i = 0; i < 200 && cnt_w[0] != 8'd11; i++) cycle();
    check("reach_11", cnt_w[0], 11);
    cycle();
    check("seg_0b", seg_w[0], 14'b1000000_0000011);
    wait_tick(0, n);
    check("up_wrap_count", cnt_w[0], 0);
    check("up_wrap_pulse", wrap_w[0], 1);
    cycle();
    check("up_wrap_one_cycle", wrap_w[0], 0);

    // Down-count wrap from reset
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    up    = 1'b0;
    wait_tick(0, n);
    check("down_wrap_count", cnt_w[0], 11);
    check("down_wrap_pulse", wrap_w[0], 1);
    wait_tick(0, n);
    check("down_next_count", cnt_w[0], 10);
    check("down_next_wrap", wrap_w[0], 0);

    // Pause with the prescaler mid-way
    wait_presc(0, 4);
    frozen = m_presc[0];
    en = 1'b0;
    repeat (25) begin
      cycle();
      check("pause_tick", tick_w[0], 0);
      check("pause_count", cnt_w[0], 10);
    end
    en = 1'b1;
    wait_tick(0, n);
    check("resume_lat", n, DIV - frozen);

    // Loads: on a step cycle, clamped, and while disabled
    wait_presc(0, DIV - 1);
    load     = 1'b1;
    load_val = 8'd7;
    cycle();
    load = 1'b0;
    check("load_step_count", cnt_w[0], 7);
    check("load_step_wrap", wrap_w[0], 0);
    check("load_step_tick", tick_w[0], 0);
    load     = 1'b1;
    load_val = 8'd200;
    cycle();
    load = 1'b0;
    check("load_clamp", cnt_w[0], 11);
    check("load_noclamp256", cnt_w[1], 200);
    en       = 1'b0;
    load     = 1'b1;
    load_val = 8'd3;
    cycle();
    load = 1'b0;
    check("load_disabled", cnt_w[0], 3);
    en = 1'b1;

    // Full-range wrap from FF on the MODULO=256 instance
    up       = 1'b1;
    load     = 1'b1;
    load_val = 8'hFF;
    cycle();
    load = 1'b0;
    check("load_ff", cnt_w[1], 255);
    wait_presc(1, DIV - 1);
    check("seg_ff", seg_w[1], 14'b0001110_0001110);
    cycle();
    check("ff_wrap_count", cnt_w[1], 0);
    check("ff_wrap_pulse", wrap_w[1], 1);

    // Randomized traffic
    repeat (800) begin
      reset    = ($urandom_range(0, 99) != 0);
      en       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) up = ~up;
      load     = ($urandom_range(0, 39) == 0);
      load_val = 8'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
